ppu_px_sink: RTL

PPU_PX_SINK -- requirements
Module: ppu_px_sink

---
 rtl/ppu_px_sink.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_px_sink.sv
// ppu_px_sink: captures the PPU pixel stream and packs four 2-bit pixels per
// framebuffer byte (first pixel in [7:6]), 40 bytes per line, 144 lines.
// Optional double buffering is enabled with `define PPU_PX_SINK_DBL_BUF_EN.
module ppu_px_sink (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCD_EN,
    input  logic [1:0]  PPU_MODE,
    input  logic [1:0]  PX_OUT,
    input  logic        PX_valid,
    input  logic        ERR_CLR,
    output logic        FB_WR,
    output logic [13:0] FB_ADDR,
    output logic [7:0]  FB_DATA,
    output logic        FRAME_DONE,
    output logic        FB_BANK,
    output logic [7:0]  CUR_LY,
    output logic        ERR_SHORT,
    output logic        ERR_OVERRUN
);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_WAIT_VB   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    state_t      state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [5:0]  pack_q, pack_d;
    logic [7:0]  ly_q, ly_d;
    logic [1:0]  prev_mode_q;
    logic        wr_q, wr_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        bank_q, bank_d;
    logic        err_short_q, err_short_d;
    logic        err_ovr_q, err_ovr_d;
    logic        set_short, set_ovr;

    logic        vb_entry;
    logic [12:0] line_base;
    logic [12:0] wr_offset;
    logic [7:0]  partial_byte;
    logic        has_partial;

    // V_BLANK is acted on only at its first cycle so a long V_BLANK pulses once
    assign vb_entry    = (PPU_MODE == MODE_VBLANK) && (prev_mode_q != MODE_VBLANK);
    // CUR_LY * 40 as (ly << 5) + (ly << 3)
    assign line_base   = {ly_q, 5'b0} + {2'b0, ly_q, 3'b0};
    // col_q is the count before the current pixel, so col_q/4 is the byte index
    assign wr_offset   = line_base + {7'b0, col_q[7:2]};
    assign has_partial = (col_q[1:0] != 2'd0);

    // left-justify the pixels held in the pack register, zero-padding the tail
    always_comb begin
        case (col_q[1:0])
            2'd1:    partial_byte = {pack_q[1:0], 6'b0};
            2'd2:    partial_byte = {pack_q[3:0], 4'b0};
            2'd3:    partial_byte = {pack_q[5:0], 2'b0};
            default: partial_byte = 8'h00;
        endcase
    end

    // state register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            col_q       <= 8'd0;
            pack_q      <= 6'd0;
            ly_q        <= 8'd0;
            prev_mode_q <= 2'd0;
            wr_q        <= 1'b0;
            addr_q      <= 13'd0;
            data_q      <= 8'd0;
            done_q      <= 1'b0;
            bank_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            pack_q      <= pack_d;
            ly_q        <= ly_d;
            prev_mode_q <= PPU_MODE;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            bank_q      <= bank_d;
            err_short_q <= err_short_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    // next-state logic; LCD off always returns to SYNC
    always_comb begin
        state_d = state_q;
        if (!LCD_EN) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (PPU_MODE == MODE_VBLANK) state_d = ST_WAIT_LINE;
                end
                ST_WAIT_LINE: begin
                    if (!vb_entry && PPU_MODE == MODE_DRAW) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (vb_entry)
                        state_d = ST_WAIT_LINE;
                    else if (PPU_MODE != MODE_DRAW)
                        state_d = (ly_q == 8'd143) ? ST_WAIT_VB : ST_WAIT_LINE;
                end
                ST_WAIT_VB: begin
                    if (vb_entry) state_d = ST_WAIT_LINE;
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // datapath / output next values: packing, writes, line and frame bookkeeping
    always_comb begin
        col_d     = col_q;
        pack_d    = pack_q;
        ly_d      = ly_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        set_short = 1'b0;
        set_ovr   = 1'b0;
        if (!LCD_EN) begin
            col_d  = 8'd0;
            pack_d = 6'd0;
            ly_d   = 8'd0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    col_d  = 8'd0;
                    pack_d = 6'd0;
                    if (PPU_MODE == MODE_VBLANK) ly_d = 8'd0;
                end
                ST_WAIT_LINE: begin
                    if (vb_entry) begin
                        // frame ended without reaching 144 lines
                        done_d    = 1'b1;
                        ly_d      = 8'd0;
                        set_short = 1'b1;
                    end else if (PPU_MODE == MODE_DRAW) begin
                        col_d  = 8'd0;
                        pack_d = 6'd0;
                    end
                end
                ST_CAPTURE: begin
                    if (PPU_MODE != MODE_DRAW) begin
                        if (has_partial) begin
                            wr_d   = 1'b1;
                            addr_d = wr_offset;
                            data_d = partial_byte;
                        end
                        if (col_q < 8'd160) set_short = 1'b1;
                        col_d  = 8'd0;
                        pack_d = 6'd0;
                        if (vb_entry) begin
                            done_d = 1'b1;
                            ly_d   = 8'd0;
                            if (ly_q != 8'd143) set_short = 1'b1;
                        end else begin
                            ly_d = ly_q + 8'd1;
                        end
                    end else if (PX_valid) begin
                        if (col_q < 8'd160) begin
                            pack_d = {pack_q[3:0], PX_OUT};
                            col_d  = col_q + 8'd1;
                            if (col_q[1:0] == 2'd3) begin
                                wr_d   = 1'b1;
                                addr_d = wr_offset;
                                data_d = {pack_q, PX_OUT};
                            end
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end
                end
                ST_WAIT_VB: begin
                    if (vb_entry) begin
                        done_d = 1'b1;
                        ly_d   = 8'd0;
                    end else if (PPU_MODE == MODE_DRAW) begin
                        set_ovr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // sticky flags: a set in the same cycle as a clear wins
    assign err_short_d = (err_short_q & ~ERR_CLR) | set_short;
    assign err_ovr_d   = (err_ovr_q & ~ERR_CLR) | set_ovr;

`ifdef PPU_PX_SINK_DBL_BUF_EN
    // flip after the FRAME_DONE cycle so a frame-end flush stays in the old bank
    assign bank_d = bank_q ^ done_q;
`else
    assign bank_d = 1'b0;
`endif

    assign FB_WR       = wr_q;
    assign FB_ADDR     = {bank_q, addr_q};
    assign FB_DATA     = data_q;
    assign FRAME_DONE  = done_q;
    assign FB_BANK     = bank_q;
    assign CUR_LY      = ly_q;
    assign ERR_SHORT   = err_short_q;
    assign ERR_OVERRUN = err_ovr_q;

endmodule
